// File: rtl/sdiv_share_arbiter.sv
// Time-shares one external combinational signed divider between two requesters.
// Round-robin grant, latched operands, divide-by-zero screening, held valid/ready response.
module sdiv_share_arbiter #(
  parameter int WIDTH = 7
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] div_in0,
  output logic [WIDTH-1:0] div_in1,
  input  logic [WIDTH-1:0] div_out,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_q,
  output logic             resp_dbz,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_resp_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_q;
  logic             r_dbz;
  logic             r_valid;
  logic             r_busy;

  logic w_grant_any;
  logic w_grant_id;
  logic w_accept;
  logic w_b_zero;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    w_grant_any = req0_valid | req1_valid;
    w_grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant_id = ~r_last_grant;
    end else if (req1_valid) begin
      w_grant_id = 1'b1;
    end
  end

  // Readies are gated by the reset pin so they drop the moment reset asserts.
  assign w_accept   = ASYNCRESETN && (r_state == S_IDLE) && w_grant_any;
  assign req0_ready = w_accept && !w_grant_id;
  assign req1_ready = w_accept &&  w_grant_id;
  assign w_b_zero   = (r_b == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_resp_id    <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_q          <= '0;
      r_dbz        <= 1'b0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a          <= w_grant_id ? req1_a : req0_a;
            r_b          <= w_grant_id ? req1_b : req0_b;
            r_resp_id    <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_busy       <= 1'b1;
            r_state      <= S_CALC;
          end
        end
        S_CALC: begin
          // The divider output is meaningless for a zero divisor; report 0 instead.
          r_q     <= w_b_zero ? '0 : div_out;
          r_dbz   <= w_b_zero;
          r_valid <= 1'b1;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign div_in0    = r_a;
  assign div_in1    = r_b;
  assign resp_valid = r_valid;
  assign resp_id    = r_resp_id;
  assign resp_q     = r_q;
  assign resp_dbz   = r_dbz;
  assign busy       = r_busy;

endmodule

// File: tb/tb_sdiv_share_arbiter.sv
// Self-checking bench for sdiv_share_arbiter: directed vector table, corner sequences,
// and randomized traffic scored against an arithmetic reference model.
module tb_sdiv_share_arbiter;

  localparam int W = 7;

  logic         CLK = 1'b0;
  logic         ASYNCRESETN;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [W-1:0] div_in0, div_in1, div_out;
  logic         resp_valid, resp_ready, resp_id, resp_dbz, busy;
  logic [W-1:0] resp_q;

  int errors = 0;
  int checks = 0;
  logic m_last;

  always #5 CLK = ~CLK;

  sdiv_share_arbiter #(.WIDTH(W)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .div_in0(div_in0), .div_in1(div_in1), .div_out(div_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_q(resp_q), .resp_dbz(resp_dbz), .busy(busy)
  );

  // Stand-in for the external divider; emits junk for a zero divisor.
  always_comb begin
    int qi;
    qi = 0;
    if (div_in1 == '0) begin
      div_out = 7'h2A;
    end else begin
      qi      = int'($signed(div_in0)) / int'($signed(div_in1));
      div_out = qi[W-1:0];
    end
  end

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic         dbz;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Sign-magnitude truncating division, wrapped to W bits.
  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    int na, nb, mag, q;
    na = int'($signed(a));
    nb = int'($signed(b));
    if (nb == 0) return '0;
    mag = (na < 0 ? -na : na) / (nb < 0 ? -nb : nb);
    q   = ((na < 0) != (nb < 0)) ? -mag : mag;
    return q[W-1:0];
  endfunction

  function automatic void add_vec(input logic id, input int a, input int b, input int q, input logic dbz);
    vec_t v;
    v.id = id; v.a = a[W-1:0]; v.b = b[W-1:0]; v.q = q[W-1:0]; v.dbz = dbz;
    vecs.push_back(v);
  endfunction

  // One operation from a single requester; response consumed immediately.
  task automatic do_op(input string nm, input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic dbz);
    req0_valid = !id; req1_valid = id;
    req0_a = a; req0_b = b; req1_a = a; req1_b = b;
    #1;
    check({nm, ".ready0"}, req0_ready, !id);
    check({nm, ".ready1"}, req1_ready, id);
    tick();
    m_last = id;
    req0_valid = 0; req1_valid = 0;
    check({nm, ".div_in0"}, div_in0, a);
    check({nm, ".div_in1"}, div_in1, b);
    check({nm, ".calc_valid"}, resp_valid, 0);
    tick();
    check({nm, ".valid"}, resp_valid, 1);
    check({nm, ".id"}, resp_id, id);
    check({nm, ".q"}, resp_q, q);
    check({nm, ".dbz"}, resp_dbz, dbz);
    resp_ready = 1;
    tick();
    resp_ready = 0;
    check({nm, ".drop"}, resp_valid, 0);
    check({nm, ".idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ASYNCRESETN = 0; resp_ready = 0;
    req0_valid = 1; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    m_last = 1;

    add_vec(0, -20,  3,  -6, 0);
    add_vec(1,  17,  0,   0, 1);
    add_vec(1,  17,  5,   3, 0);
    add_vec(0, -64, -1, -64, 0);
    add_vec(0,  63, -7,  -9, 0);
    add_vec(1,  -7,  2,  -3, 0);
    add_vec(0,   5, -8,   0, 0);
    add_vec(1, -64,  1, -64, 0);
    add_vec(0,   0,  0,   0, 1);

    // Reset state
    #3;
    check("rst.ready0", req0_ready, 0);
    check("rst.valid", resp_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.div_in0", div_in0, 0);
    check("rst.q", resp_q, 0);
    req0_valid = 0;
    #9 ASYNCRESETN = 1;
    tick();

    // Tie after reset: req0 first, then alternation with both held valid
    req0_a = 7'd9; req0_b = 7'd2; req1_a = 7'h77; req1_b = 7'd2;
    req0_valid = 1; req1_valid = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr.ready0", req0_ready, (k % 2) == 0);
      check("rr.ready1", req1_ready, (k % 2) == 1);
      tick();
      m_last = (k % 2);
      check("rr.calc_ready", {req0_ready, req1_ready}, 2'b00);
      tick();
      check("rr.id", resp_id, (k % 2));
      check("rr.q", resp_q, (k % 2) ? 7'h7C : 7'h04);
      resp_ready = 1;
      tick();
      resp_ready = 0;
      if (k == 3) begin
        req0_valid = 0; req1_valid = 0;
      end
    end

    // Directed vector table
    foreach (vecs[i]) do_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].dbz);

    // Held response under backpressure
    req0_valid = 1; req0_a = 7'd100; req0_b = 7'd7;
    #1;
    check("bp.ready0", req0_ready, 1);
    tick();
    m_last = 0;
    req1_valid = 1;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp.valid", resp_valid, 1);
      check("bp.q", resp_q, ref_q(7'd100, 7'd7));
      check("bp.id", resp_id, 0);
      check("bp.busy", busy, 1);
      check("bp.readies", {req0_ready, req1_ready}, 2'b00);
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    resp_ready = 1;
    tick();
    resp_ready = 0;
    check("bp.drop", resp_valid, 0);

    // Randomized traffic vs. reference model
    for (int it = 0; it < 60; it++) begin
      logic v0, v1, g;
      logic [W-1:0] a0, b0, a1, b1, ea, eb;
      int r, hold;
      v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
      a0 = 7'($urandom_range(0, 127)); a1 = 7'($urandom_range(0, 127));
      r = $urandom_range(0, 7); b0 = (r == 0) ? 7'd0 : (r == 1) ? 7'h7F : 7'($urandom_range(0, 127));
      r = $urandom_range(0, 7); b1 = (r == 0) ? 7'd0 : (r == 1) ? 7'h7F : 7'($urandom_range(0, 127));
      if (r == 2) a1 = 7'h40;
      req0_valid = v0; req1_valid = v1;
      req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
      #1;
      if (!v0 && !v1) begin
        check("rnd.noreq", {req0_ready, req1_ready}, 2'b00);
        tick();
        continue;
      end
      g  = (v0 && v1) ? !m_last : v1;
      ea = g ? a1 : a0;
      eb = g ? b1 : b0;
      check("rnd.ready0", req0_ready, !g);
      check("rnd.ready1", req1_ready, g);
      tick();
      m_last = g;
      req0_valid = 0; req1_valid = 0;
      tick();
      check("rnd.valid", resp_valid, 1);
      check("rnd.id", resp_id, g);
      check("rnd.q", resp_q, ref_q(ea, eb));
      check("rnd.dbz", resp_dbz, eb == '0);
      hold = $urandom_range(0, 2);
      for (int k = 0; k < hold; k++) begin
        tick();
        check("rnd.hold", {resp_valid, resp_q}, {1'b1, ref_q(ea, eb)});
      end
      resp_ready = 1;
      tick();
      resp_ready = 0;
      check("rnd.drop", resp_valid, 0);
    end

    // Async reset in the middle of CALC
    req1_valid = 1; req1_a = 7'd17; req1_b = 7'd5;
    #1;
    check("ar.ready1", req1_ready, 1);
    tick();
    req1_valid = 0; req0_valid = 1;
    #2 ASYNCRESETN = 0;
    #1;
    m_last = 1;
    check("ar.valid", resp_valid, 0);
    check("ar.busy", busy, 0);
    check("ar.div", {div_in0, div_in1}, 14'd0);
    check("ar.ready0", req0_ready, 0);
    req0_valid = 0;
    #2 ASYNCRESETN = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("ar.noresp", resp_valid, 0);
    end
    req0_valid = 1; req1_valid = 1;
    req0_a = 7'h6C; req0_b = 7'd3; req1_a = 7'd1; req1_b = 7'd1;
    #1;
    check("ar.tie0", {req0_ready, req1_ready}, 2'b10);
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
    check("ar.id", resp_id, 0);
    check("ar.q", resp_q, 7'h7A);
    resp_ready = 1;
    tick();
    resp_ready = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
